// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU request sequencer.
// Holds FSM encodings, opcode values and the reserved-opcode range.
package alu_ctrl_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_OP_W  = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_EXEC = 3'd2,
    ST_WB   = 3'd3
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_PASS = 3'd5;

  localparam logic [2:0] OP_RSV_LO = 3'd6;
  localparam logic [2:0] OP_RSV_HI = 3'd7;

  // Top of the range equals the largest 3-bit code, so only
  // the lower bound needs comparing.
  function automatic logic op_reserved(
    input logic [DEF_OP_W-1:0] op
  );
    return op >= OP_RSV_LO;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational.
// Ports: req0/req1 requests, ptr = last winner id, win = one-hot pick.
module rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       ptr,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    unique case (1'b1)
      (req0 & ~req1): win = 2'b01;
      (~req0 & req1): win = 2'b10;
      // On contention the requester that did not win last goes.
      (req0 & req1):  win = ptr ? 2'b01 : 2'b10;
      default:        win = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_rr_sequencer.sv
// Shares one ALU between two requesters: round-robin grant, then
// LOAD/EXEC/WB sequence with a done pulse to the owner.
// Ports: clk, rst_n (sync, active-high), req/a/b/op per requester,
// alu_a/alu_b/alu_op to ALU, alu_y/alu_c back, result/carry regs,
// done0/done1 pulses, grant one-hot owner, state debug.
// Macro ALU_OPCHK_EN: reserved opcodes yield zero result and err.
module alu_rr_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OP_W  = DEF_OP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [OP_W-1:0]  op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [OP_W-1:0]  op1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_c,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             done0,
  output logic             done1,
  output logic [1:0]       grant,
`ifdef ALU_OPCHK_EN
  output logic             err,
`endif
  output logic [2:0]       state
);

  state_t           cur;
  state_t           nxt;
  logic             ptr;
  logic [1:0]       win;
  logic [WIDTH-1:0] reg1;
  logic [WIDTH-1:0] reg2;
  logic [OP_W-1:0]  opr;
  logic             rsv;
  logic             in_wb;

  rr_arb2 u_arb (
    .req0 (req0),
    .req1 (req1),
    .ptr  (ptr),
    .win  (win)
  );

`ifdef ALU_OPCHK_EN
  assign rsv = op_reserved(opr);
`else
  assign rsv = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cur    <= ST_IDLE;
      grant  <= 2'b00;
      ptr    <= 1'b1;
      reg1   <= '0;
      reg2   <= '0;
      opr    <= '0;
      result <= '0;
      carry  <= 1'b0;
    end else begin
      cur <= nxt;
      case (cur)
        ST_IDLE: begin
          grant <= win;
          if (|win) begin
            ptr  <= win[1];
            reg1 <= win[0] ? a0 : a1;
            reg2 <= win[0] ? b0 : b1;
            opr  <= win[0] ? op0 : op1;
          end
        end
        ST_LOAD: ;
        ST_EXEC: begin
          result <= rsv ? '0 : alu_y;
          carry  <= rsv ? 1'b0 : alu_c;
        end
        default: grant <= 2'b00;
      endcase
    end
  end

  always_comb begin
    nxt    = ST_IDLE;
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    case (cur)
      ST_IDLE: nxt = (|win) ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        nxt    = ST_EXEC;
        alu_a  = reg1;
        alu_b  = reg2;
        alu_op = rsv ? '0 : opr;
      end
      ST_EXEC: begin
        nxt    = ST_WB;
        alu_a  = reg1;
        alu_b  = reg2;
        alu_op = rsv ? '0 : opr;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  assign in_wb = (cur == ST_WB);
  assign done0 = in_wb & grant[0];
  assign done1 = in_wb & grant[1];
  assign state = cur;

`ifdef ALU_OPCHK_EN
  assign err = in_wb & rsv;
`endif

endmodule
